// File: rtl/rvc_asap_dmem_arb_if.sv
// Data-memory arbitration bundle: core Q103H port, external valid/ready master,
// and the single memory port. The arbiter uses the slave modport.
interface rvc_asap_dmem_arb_if;
    logic [31:0] CoreWrDataQ103H;
    logic [31:0] CoreAddressQ103H;
    logic [3:0]  CoreByteEnQ103H;
    logic        CoreWrEnQ103H;
    logic        CoreRdEnQ103H;
    logic        CoreStallQ103H;
    logic [31:0] CoreRdRspQ104H;

    logic        ExtReqValid;
    logic        ExtReqWrEn;
    logic [31:0] ExtAddress;
    logic [31:0] ExtWrData;
    logic [3:0]  ExtByteEn;
    logic        ExtReqReady;
    logic        ExtRspValid;
    logic [31:0] ExtRdRsp;

    logic [31:0] DMemWrDataQ103H;
    logic [31:0] DMemAddressQ103H;
    logic [3:0]  DMemByteEnQ103H;
    logic        DMemWrEnQ103H;
    logic        DMemRdEnQ103H;
    logic [31:0] DMemRdRspQ104H;

    modport slave (
        input  CoreWrDataQ103H, CoreAddressQ103H, CoreByteEnQ103H,
        input  CoreWrEnQ103H, CoreRdEnQ103H,
        output CoreStallQ103H, CoreRdRspQ104H,
        input  ExtReqValid, ExtReqWrEn, ExtAddress, ExtWrData, ExtByteEn,
        output ExtReqReady, ExtRspValid, ExtRdRsp,
        output DMemWrDataQ103H, DMemAddressQ103H, DMemByteEnQ103H,
        output DMemWrEnQ103H, DMemRdEnQ103H,
        input  DMemRdRspQ104H
    );

    modport master (
        output CoreWrDataQ103H, CoreAddressQ103H, CoreByteEnQ103H,
        output CoreWrEnQ103H, CoreRdEnQ103H,
        input  CoreStallQ103H, CoreRdRspQ104H,
        output ExtReqValid, ExtReqWrEn, ExtAddress, ExtWrData, ExtByteEn,
        input  ExtReqReady, ExtRspValid, ExtRdRsp,
        input  DMemWrDataQ103H, DMemAddressQ103H, DMemByteEnQ103H,
        input  DMemWrEnQ103H, DMemRdEnQ103H,
        output DMemRdRspQ104H
    );
endinterface

// File: rtl/rvc_asap_dmem_arb.sv
// Core-priority data-memory arbiter with a starvation counter that forces one
// external slot after MAX_WAIT blocked cycles; read data is routed by owner.
module rvc_asap_dmem_arb #(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned CNT_W    = 8
) (
    input logic                 Clock,
    input logic                 Rst,
    rvc_asap_dmem_arb_if.slave  bus
);

    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_rsp_pend;
    logic             r_rsp_owner;

    logic w_core_req;
    logic w_force_ext;
    logic w_gnt_ext;
    logic w_gnt_core;

    always_comb begin
        w_core_req  = bus.CoreWrEnQ103H | bus.CoreRdEnQ103H;
        w_force_ext = bus.ExtReqValid & (r_wait_cnt == LP_MAX);
        w_gnt_ext   = ~Rst & bus.ExtReqValid & (~w_core_req | w_force_ext);
        w_gnt_core  = ~Rst & w_core_req & ~w_gnt_ext;
    end

    always_comb begin
        bus.ExtReqReady      = w_gnt_ext;
        bus.CoreStallQ103H   = w_core_req & w_gnt_ext;
        bus.DMemWrDataQ103H  = '0;
        bus.DMemAddressQ103H = '0;
        bus.DMemByteEnQ103H  = '0;
        bus.DMemWrEnQ103H    = 1'b0;
        bus.DMemRdEnQ103H    = 1'b0;
        if (w_gnt_ext) begin
            bus.DMemWrDataQ103H  = bus.ExtWrData;
            bus.DMemAddressQ103H = bus.ExtAddress;
            bus.DMemByteEnQ103H  = bus.ExtByteEn;
            bus.DMemWrEnQ103H    = bus.ExtReqWrEn;
            bus.DMemRdEnQ103H    = ~bus.ExtReqWrEn;
        end else if (w_gnt_core) begin
            bus.DMemWrDataQ103H  = bus.CoreWrDataQ103H;
            bus.DMemAddressQ103H = bus.CoreAddressQ103H;
            bus.DMemByteEnQ103H  = bus.CoreByteEnQ103H;
            bus.DMemWrEnQ103H    = bus.CoreWrEnQ103H;
            bus.DMemRdEnQ103H    = bus.CoreRdEnQ103H;
        end
    end

    // Counter only advances while the external request is actually blocked.
    always_ff @(posedge Clock) begin
        if (Rst || w_gnt_ext) begin
            r_wait_cnt <= '0;
        end else if (bus.ExtReqValid && (r_wait_cnt != LP_MAX)) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            r_rsp_pend  <= 1'b0;
            r_rsp_owner <= 1'b0;
        end else begin
            r_rsp_pend  <= bus.DMemRdEnQ103H;
            r_rsp_owner <= w_gnt_ext;
        end
    end

    always_comb begin
        bus.ExtRspValid    = ~Rst & r_rsp_pend & r_rsp_owner;
        bus.ExtRdRsp       = bus.DMemRdRspQ104H;
        bus.CoreRdRspQ104H = bus.DMemRdRspQ104H;
    end

endmodule

// File: tb/tb_rvc_asap_dmem_arb.sv
// Randomized bench for rvc_asap_dmem_arb: a cycle-level reference model of the
// arbitration rules predicts every memory-side and response-side output.
module tb_rvc_asap_dmem_arb;

    localparam int MAXW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rvc_asap_dmem_arb_if bus ();

    rvc_asap_dmem_arb #(.MAX_WAIT(MAXW), .CNT_W(8)) dut (
        .Clock (clk),
        .Rst   (rst),
        .bus   (bus)
    );

    // Memory stand-in: read data is a fixed function of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
    endfunction

    always @(posedge clk) begin
        if (bus.DMemRdEnQ103H) bus.DMemRdRspQ104H <= memf(bus.DMemAddressQ103H);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int          m_blocked = 0;     // consecutive cycles the external request was refused
    bit          m_pend    = 0;
    bit          m_owner   = 0;
    logic [31:0] m_rsp_addr = '0;
    bit          m_gnt_ext, m_stall;

    task automatic drive(input bit cwr, input bit crd, input logic [31:0] caddr,
                         input logic [31:0] cdata, input logic [3:0] cbe,
                         input bit ev, input bit ewr, input logic [31:0] eaddr,
                         input logic [31:0] edata, input logic [3:0] ebe);
        bus.CoreWrEnQ103H    = cwr;
        bus.CoreRdEnQ103H    = crd;
        bus.CoreAddressQ103H = caddr;
        bus.CoreWrDataQ103H  = cdata;
        bus.CoreByteEnQ103H  = cbe;
        bus.ExtReqValid      = ev;
        bus.ExtReqWrEn       = ewr;
        bus.ExtAddress       = eaddr;
        bus.ExtWrData        = edata;
        bus.ExtByteEn        = ebe;
    endtask

    // Evaluate one cycle: check all outputs against the model, then advance it.
    task automatic step();
        bit          creq, gcore, ev, rspv;
        logic [31:0] ea, ed;
        logic [3:0]  eb;
        bit          ew, er;
        #1;
        creq = bus.CoreWrEnQ103H | bus.CoreRdEnQ103H;
        ev   = bus.ExtReqValid;
        m_gnt_ext = 0;
        if (!rst && ev) m_gnt_ext = !creq || (m_blocked >= MAXW);
        gcore   = !rst && creq && !m_gnt_ext;
        m_stall = creq && m_gnt_ext;
        ea = '0; ed = '0; eb = '0; ew = 0; er = 0;
        if (m_gnt_ext) begin
            ea = bus.ExtAddress; ed = bus.ExtWrData; eb = bus.ExtByteEn;
            ew = bus.ExtReqWrEn; er = !bus.ExtReqWrEn;
        end else if (gcore) begin
            ea = bus.CoreAddressQ103H; ed = bus.CoreWrDataQ103H; eb = bus.CoreByteEnQ103H;
            ew = bus.CoreWrEnQ103H; er = bus.CoreRdEnQ103H;
        end
        rspv = !rst && m_pend && m_owner;

        check("ready",   32'(bus.ExtReqReady),     32'(m_gnt_ext));
        check("stall",   32'(bus.CoreStallQ103H),  32'(m_stall));
        check("mem_wr",  32'(bus.DMemWrEnQ103H),   32'(ew));
        check("mem_rd",  32'(bus.DMemRdEnQ103H),   32'(er));
        check("mem_adr", bus.DMemAddressQ103H,     ea);
        check("mem_dat", bus.DMemWrDataQ103H,      ed);
        check("mem_be",  32'(bus.DMemByteEnQ103H), 32'(eb));
        check("rsp_vld", 32'(bus.ExtRspValid),     32'(rspv));
        check("waitcnt", 32'(dut.r_wait_cnt),      32'(m_blocked));
        if (rspv) check("ext_rsp", bus.ExtRdRsp, memf(m_rsp_addr));
        if (!rst && m_pend && !m_owner) check("core_rsp", bus.CoreRdRspQ104H, memf(m_rsp_addr));

        @(posedge clk);
        if (rst) begin
            m_blocked = 0; m_pend = 0; m_owner = 0;
        end else begin
            if (m_gnt_ext) m_blocked = 0;
            else if (ev && m_blocked < MAXW) m_blocked++;
            m_pend = er; m_owner = m_gnt_ext; m_rsp_addr = ea;
        end
        @(negedge clk);
    endtask

    bit          c_wr, c_rd, e_v, e_wr;
    logic [31:0] c_a, c_d, e_a, e_d;
    logic [3:0]  c_b, e_b;

    initial begin
        rst = 1'b1;
        drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
        @(negedge clk);
        step(); step();
        rst = 1'b0;

        // Core-only load, then ext read, then ext write with partial byte enables
        drive(0, 1, 32'h0000_1004, '0, 4'hF, 0, 0, '0, '0, '0); step();
        drive(0, 0, '0, '0, '0, 1, 0, 32'h0000_2000, '0, 4'hF); step();
        drive(0, 0, '0, '0, '0, 1, 1, 32'h0000_3000, 32'hDEAD_BEEF, 4'b0011); step();
        drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0); step();

        // Starvation: core stores every cycle while an ext read waits
        for (int i = 0; i < 11; i++) begin
            drive(1, 0, 32'h100 + 32'(i), 32'hC0DE_0000 + 32'(i), 4'hF,
                  (i < 9), 0, 32'h0000_4000, '0, 4'hF);
            step();
        end

        // Interleaved core load at n, ext read at n+1
        drive(0, 1, 32'h0000_5004, '0, 4'hF, 0, 0, '0, '0, '0); step();
        drive(0, 0, '0, '0, '0, 1, 0, 32'h0000_6000, '0, 4'hF); step();
        drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0); step();

        // Reset the cycle after an ext read grant
        drive(0, 0, '0, '0, '0, 1, 0, 32'h0000_7000, '0, 4'hF); step();
        rst = 1'b1;
        drive(1, 0, 32'h88, 32'h1, 4'hF, 1, 0, 32'h0000_7004, '0, 4'hF); step(); step();
        rst = 1'b0;
        drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0); step();

        // Random traffic; held requests keep their fields until served
        c_wr = 0; c_rd = 0; e_v = 0; e_wr = 0;
        c_a = '0; c_d = '0; c_b = '0; e_a = '0; e_d = '0; e_b = '0;
        m_stall = 0; m_gnt_ext = 0;
        for (int i = 0; i < 600; i++) begin
            if (!((c_wr || c_rd) && m_stall)) begin
                int r = int'($urandom_range(0, 7));
                c_wr = (r >= 5); c_rd = (r >= 2 && r < 5);
                c_a = {16'h0, 16'($urandom)} & 32'hFFFF_FFFC;
                c_d = $urandom; c_b = 4'($urandom);
            end
            if (!(e_v && !m_gnt_ext)) begin
                e_v = ($urandom_range(0, 2) != 0);
                e_wr = ($urandom_range(0, 3) == 0);
                e_a = {16'h1, 16'($urandom)} & 32'hFFFF_FFFC;
                e_d = $urandom; e_b = 4'($urandom);
            end
            rst = ($urandom_range(0, 79) == 0);
            drive(c_wr, c_rd, c_a, c_d, c_b, e_v, e_wr, e_a, e_d, e_b);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
